// File: rtl/synth_ctrl.sv
// Synth front-panel controller: debounced keys drive waveform select, base frequency and an
// optional octave arpeggiator (built only when SYNTH_CTRL_ARP_EN is defined).
module synth_ctrl #(
    parameter int          FCW_WIDTH       = 24,
    parameter int unsigned FCW_STEP        = 2**18,
    parameter int          DEBOUNCE_CYCLES = 1920,
    parameter int          TEMPO_SAMPLES   = 12000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           key_n,
    input  logic                 advance,
    output logic [1:0]           sel,
    output logic [FCW_WIDTH-1:0] fcw,
    output logic                 arp_run,
    output logic [1:0]           arp_step
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0]       DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCW_WIDTH:0]   STEP_X   = (FCW_WIDTH + 1)'(FCW_STEP);
    localparam logic [FCW_WIDTH-1:0] ALL_ONES = '1;

    function automatic logic [FCW_WIDTH-1:0] sat_up(input logic [FCW_WIDTH-1:0] b);
        logic [FCW_WIDTH:0] s;
        s = {1'b0, b} + STEP_X;
        return s[FCW_WIDTH] ? ALL_ONES : s[FCW_WIDTH-1:0];
    endfunction

    function automatic logic [FCW_WIDTH-1:0] sat_down(input logic [FCW_WIDTH-1:0] b);
        return ({1'b0, b} < STEP_X) ? '0 : (b - STEP_X[FCW_WIDTH-1:0]);
    endfunction

    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     db_q, db_d;
    logic [3:0]     press_q, press_d;
    logic [DBW-1:0] cnt_q [4];
    logic [DBW-1:0] cnt_d [4];

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = db_q & ~db_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            press_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    logic                 up_press, down_press;
    logic [1:0]           sel_pend_q, sel_q;
    logic [FCW_WIDTH-1:0] base_q, fcw_q, eff_word;

    assign up_press   = press_q[1] & ~press_q[2];
    assign down_press = press_q[2] & ~press_q[1];

    // Outputs take the values pending before this edge, so a press coincident with advance waits
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_pend_q <= 2'd3;
            base_q     <= '0;
            sel_q      <= 2'd3;
            fcw_q      <= '0;
        end else begin
            if (press_q[0]) sel_pend_q <= sel_pend_q + 1'b1;
            if (up_press) begin
                base_q <= sat_up(base_q);
            end else if (down_press) begin
                base_q <= sat_down(base_q);
            end
            if (advance) begin
                sel_q <= sel_pend_q;
                fcw_q <= eff_word;
            end
        end
    end

`ifdef SYNTH_CTRL_ARP_EN
    localparam int TW = (TEMPO_SAMPLES > 1) ? $clog2(TEMPO_SAMPLES) : 1;
    localparam logic [TW-1:0] TEMPO_LAST = TW'(TEMPO_SAMPLES - 1);

    // Octave pattern 0,1,2,1 across the four steps; overflow saturates to all-ones
    function automatic logic [FCW_WIDTH-1:0] oct_shift(input logic [FCW_WIDTH-1:0] b,
                                                       input logic [1:0] step);
        logic [FCW_WIDTH+1:0] w;
        case (step)
            2'd0:    w = {2'b00, b};
            2'd2:    w = {b, 2'b00};
            default: w = {1'b0, b, 1'b0};
        endcase
        return (w[FCW_WIDTH+1:FCW_WIDTH] != 2'b00) ? ALL_ONES : w[FCW_WIDTH-1:0];
    endfunction

    typedef enum logic {ARP_OFF, ARP_RUN} arp_state_t;

    arp_state_t    state_q;
    logic [TW-1:0] tempo_q;
    logic [1:0]    step_q;
    logic          run_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARP_OFF;
            tempo_q <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                ARP_OFF: begin
                    if (press_q[3]) begin
                        state_q <= ARP_RUN;
                        tempo_q <= '0;
                        step_q  <= '0;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    if (press_q[3]) begin
                        state_q <= ARP_OFF;
                        tempo_q <= '0;
                        step_q  <= '0;
                        run_q   <= 1'b0;
                    end else if (advance) begin
                        if (tempo_q == TEMPO_LAST) begin
                            tempo_q <= '0;
                            step_q  <= step_q + 1'b1;
                        end else begin
                            tempo_q <= tempo_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign eff_word = (state_q == ARP_RUN) ? oct_shift(base_q, step_q) : base_q;
    assign arp_run  = run_q;
    assign arp_step = step_q;
`else
    logic unused_run_press;

    assign unused_run_press = press_q[3];
    assign eff_word         = base_q;
    assign arp_run          = 1'b0;
    assign arp_step         = 2'd0;
`endif

    assign sel = sel_q;
    assign fcw = fcw_q;

endmodule

// File: tb/tb_synth_ctrl.sv
// Scoreboard bench for synth_ctrl: stimulus queues expected outputs, a monitor compares them
// on every advance or probe sample. Arpeggiator cases run only when SYNTH_CTRL_ARP_EN is defined.
module tb_synth_ctrl;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   key_n = 4'hF;
    logic         advance = 1'b0;
    logic [1:0]   sel, arp_step;
    logic [W-1:0] fcw;
    logic         arp_run;

    synth_ctrl #(
        .FCW_WIDTH(W),
        .FCW_STEP(2**18),
        .DEBOUNCE_CYCLES(4),
        .TEMPO_SAMPLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .advance(advance),
        .sel(sel),
        .fcw(fcw),
        .arp_run(arp_run),
        .arp_step(arp_step)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] fcw;
        logic         run;
        logic [1:0]   step;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  probe = 1'b0;
    logic  seen = 1'b0;
    exp_t  mon_e;
    string mon_n;

    localparam logic [3:0] K_WAVE = 4'b0001;
    localparam logic [3:0] K_UP   = 4'b0010;
    localparam logic [3:0] K_DOWN = 4'b0100;
    localparam logic [3:0] K_RUN  = 4'b1000;

    always @(posedge clk) seen <= advance | probe;

    always @(negedge clk) begin
        if (seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got sel=%0d fcw=%h run=%0d step=%0d, required none queued",
                         sel, fcw, arp_run, arp_step);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (sel !== mon_e.sel || fcw !== mon_e.fcw || arp_run !== mon_e.run || arp_step !== mon_e.step) begin
                    errors++;
                    $display("FAIL %s: got sel=%0d fcw=%h run=%0d step=%0d, required sel=%0d fcw=%h run=%0d step=%0d",
                             mon_n, sel, fcw, arp_run, arp_step, mon_e.sel, mon_e.fcw, mon_e.run, mon_e.step);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [1:0] s, input logic [W-1:0] f,
                            input logic r, input logic [1:0] st);
        exp_t e;
        e.sel = s; e.fcw = f; e.run = r; e.step = st;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic adv(input string n, input logic [1:0] s, input logic [W-1:0] f,
                       input logic r, input logic [1:0] st);
        push_exp(n, s, f, r, st);
        advance = 1'b1;
        tick(1);
        advance = 1'b0;
    endtask

    task automatic look(input string n, input logic [1:0] s, input logic [W-1:0] f,
                        input logic r, input logic [1:0] st);
        push_exp(n, s, f, r, st);
        probe = 1'b1;
        tick(1);
        probe = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask);
        key_n = ~mask;
        tick(10);
        key_n = 4'hF;
        tick(10);
    endtask

`ifdef SYNTH_CTRL_ARP_EN
    logic [W-1:0] arp_fcw  [12];
    logic [1:0]   arp_stp  [12];
`endif

    initial begin
        reset = 1'b1;
        tick(3);
        look("reset_state", 2'd3, 24'h000000, 1'b0, 2'd0);
        reset = 1'b0;
        tick(2);

        // Waveform key held 10 cycles: sel must wait for advance, then step 3 -> 0 exactly once
        key_n[0] = 1'b0;
        tick(10);
        look("sel_holds_until_advance", 2'd3, 24'h000000, 1'b0, 2'd0);
        key_n[0] = 1'b1;
        tick(10);
        adv("wave_first_press", 2'd0, 24'h000000, 1'b0, 2'd0);
        adv("wave_single_increment", 2'd0, 24'h000000, 1'b0, 2'd0);

        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0;
            tick(2);
            key_n[1] = 1'b1;
            tick(2);
        end
        tick(8);
        adv("bounce_ignored", 2'd0, 24'h000000, 1'b0, 2'd0);

        press(K_WAVE); adv("wave_to_1", 2'd1, 24'h000000, 1'b0, 2'd0);
        press(K_WAVE); adv("wave_to_2", 2'd2, 24'h000000, 1'b0, 2'd0);
        press(K_WAVE); adv("wave_to_3", 2'd3, 24'h000000, 1'b0, 2'd0);
        press(K_WAVE); adv("wave_wrap_0", 2'd0, 24'h000000, 1'b0, 2'd0);

        for (int i = 0; i < 64; i++) begin
            press(K_UP);
            adv($sformatf("up_%0d", i + 1), 2'd0,
                (i == 63) ? 24'hFFFFFF : W'((i + 1) << 18), 1'b0, 2'd0);
        end
        press(K_UP);            adv("up_saturated_hold", 2'd0, 24'hFFFFFF, 1'b0, 2'd0);
        press(K_DOWN);          adv("down_from_max", 2'd0, 24'hFBFFFF, 1'b0, 2'd0);
        press(K_UP | K_DOWN);   adv("up_down_same_cycle", 2'd0, 24'hFBFFFF, 1'b0, 2'd0);

        // Down press pulse lands in the same cycle as advance: new base waits one more advance
        key_n[2] = 1'b0;
        tick(6);
        adv("press_with_advance", 2'd0, 24'hFBFFFF, 1'b0, 2'd0);
        tick(5);
        key_n[2] = 1'b1;
        tick(10);
        adv("press_after_advance", 2'd0, 24'hF7FFFF, 1'b0, 2'd0);

        reset = 1'b1;
        look("reset_clears_all", 2'd3, 24'h000000, 1'b0, 2'd0);
        reset = 1'b0;
        tick(2);

`ifdef SYNTH_CTRL_ARP_EN
        arp_fcw = '{24'h040000, 24'h040000, 24'h040000, 24'h080000, 24'h080000, 24'h080000,
                    24'h100000, 24'h100000, 24'h100000, 24'h080000, 24'h080000, 24'h080000};
        arp_stp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        press(K_UP);  adv("arp_base_set", 2'd3, 24'h040000, 1'b0, 2'd0);
        press(K_RUN); look("arp_started", 2'd3, 24'h040000, 1'b1, 2'd0);
        for (int k = 0; k < 12; k++) begin
            adv($sformatf("arp_adv_%0d", k + 1), 2'd3, arp_fcw[k], 1'b1, arp_stp[k]);
        end
        for (int i = 0; i < 31; i++) press(K_UP);
        adv("arp_hi_step0_a", 2'd3, 24'h800000, 1'b1, 2'd0);
        adv("arp_hi_step0_b", 2'd3, 24'h800000, 1'b1, 2'd0);
        adv("arp_hi_step0_c", 2'd3, 24'h800000, 1'b1, 2'd1);
        adv("arp_step1_saturate", 2'd3, 24'hFFFFFF, 1'b1, 2'd1);
        reset = 1'b1;
        look("reset_mid_arp", 2'd3, 24'h000000, 1'b0, 2'd0);
        reset = 1'b0;
        tick(2);
        adv("after_reset_arp_off", 2'd3, 24'h000000, 1'b0, 2'd0);
`else
        press(K_UP);
        press(K_RUN);
        adv("noarp_run_ignored_a", 2'd3, 24'h040000, 1'b0, 2'd0);
        adv("noarp_run_ignored_b", 2'd3, 24'h040000, 1'b0, 2'd0);
        press(K_UP);
        adv("noarp_fcw_is_base", 2'd3, 24'h080000, 1'b0, 2'd0);
`endif

        tick(3);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never sampled, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
